// File: rtl/pipe_pkg.sv
// Shared types and ID/EX control-bundle layout for the inter-stage pipeline registers.
// The optional performance counters in pipe_stage_buf are enabled by defining PIPE_STAGE_PERF_EN.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int unsigned IDEX_DATA_W = 160;
  localparam int unsigned IDEX_CTRL_W = 17;

  // ID/EX control bundle field map, LSB first
  localparam int unsigned ALUOP_OFF    = 0;
  localparam int unsigned ALUOP_W      = 4;
  localparam int unsigned ALUSRC2_OFF  = 4;
  localparam int unsigned ALUSRC1_OFF  = 5;
  localparam int unsigned MEMTOREG_OFF = 6;
  localparam int unsigned MEMTOREG_W   = 2;
  localparam int unsigned MEMWRITE_OFF = 8;
  localparam int unsigned MEMREAD_OFF  = 9;
  localparam int unsigned REGDST_OFF   = 10;
  localparam int unsigned REGDST_W     = 2;
  localparam int unsigned REGWRITE_OFF = 12;
  localparam int unsigned BRANCH_OFF   = 13;
  localparam int unsigned PCSRC_OFF    = 14;
  localparam int unsigned PCSRC_W      = 3;

  localparam logic [IDEX_CTRL_W-1:0] IDEX_CTRL_NOP = '0;

endpackage

// File: rtl/pipe_entry_reg.sv
// One buffer slot: data, control and valid bit with load and clear.
// Clear invalidates the slot and zeroes control but leaves data untouched.
module pipe_entry_reg #(
  parameter int unsigned DATA_W = 160,
  parameter int unsigned CTRL_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register: 2-entry skid buffer with registered in_ready and synchronous flush.
// Define PIPE_STAGE_PERF_EN to add stall_cnt / flush_cnt outputs.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = IDEX_DATA_W,
  parameter int unsigned CTRL_W = IDEX_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  state_e r_state;
  state_e w_next;
  logic   r_in_ready;

  logic w_push, w_pop;
  logic w_main_load, w_main_clear, w_skid_load, w_skid_clear;

  logic              w_main_valid, w_skid_valid;
  logic [DATA_W-1:0] w_main_q_data, w_skid_q_data, w_main_d_data;
  logic [CTRL_W-1:0] w_main_q_ctrl, w_skid_q_ctrl, w_main_d_ctrl;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = w_main_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != TWO);
    end
  end

  always_comb begin
    w_next       = r_state;
    w_main_load  = 1'b0;
    w_main_clear = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    if (flush) begin
      w_next       = EMPTY;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_main_load = 1'b1;
            w_next      = ONE;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            w_main_load = 1'b1;
          end else if (w_push) begin
            w_skid_load = 1'b1;
            w_next      = TWO;
          end else if (w_pop) begin
            w_main_clear = 1'b1;
            w_next       = EMPTY;
          end
        end
        TWO: begin
          if (w_pop) begin
            w_main_load  = 1'b1;
            w_skid_clear = 1'b1;
            w_next       = ONE;
          end
        end
        default: begin
          w_next       = EMPTY;
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  // The skid slot is only ever valid in TWO, so its valid bit picks the main-entry source
  assign w_main_d_data = w_skid_valid ? w_skid_q_data : in_data;
  assign w_main_d_ctrl = w_skid_valid ? w_skid_q_ctrl : in_ctrl;

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_d_data),
    .i_ctrl  (w_main_d_ctrl),
    .o_valid (w_main_valid),
    .o_data  (w_main_q_data),
    .o_ctrl  (w_main_q_ctrl)
  );

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (in_data),
    .i_ctrl  (in_ctrl),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_q_data),
    .o_ctrl  (w_skid_q_ctrl)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = w_main_valid;
  assign out_data  = w_main_q_data;
  assign out_ctrl  = w_main_valid ? w_main_q_ctrl : '0;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_main_valid && !out_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush)                      r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf against a queue-based FIFO reference model.
// Perf counter checks are compiled in when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_buf;

  localparam int unsigned DW = 160;
  localparam int unsigned CW = 17;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt;
  logic [15:0]   flush_cnt;
  int unsigned   m_stall;
  int unsigned   m_flush;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [DW-1:0] q_data[$];
  logic [CW-1:0] q_ctrl[$];

  pipe_stage_buf #(
    .DATA_W (DW),
    .CTRL_W (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_clear();
    q_data.delete();
    q_ctrl.delete();
  endtask

  // Reference: a FIFO of depth 2; in_ready reflects the occupancy left by the previous edge
  task automatic model_edge();
    int unsigned n;
    logic push, pop;
    n    = q_data.size();
    push = in_valid && (n < 2);
    pop  = (n > 0) && out_ready;
`ifdef PIPE_STAGE_PERF_EN
    if ((n > 0) && !out_ready) m_stall++;
    if (flush) m_flush++;
`endif
    if (flush) begin
      model_clear();
    end else begin
      if (pop) begin
        void'(q_data.pop_front());
        void'(q_ctrl.pop_front());
      end
      if (push) begin
        q_data.push_back(in_data);
        q_ctrl.push_back(in_ctrl);
      end
    end
  endtask

  task automatic check_outputs();
    int unsigned n;
    n = q_data.size();
    check("out_valid", 192'(out_valid), 192'(n > 0));
    check("in_ready", 192'(in_ready), 192'(n < 2));
    check("out_ctrl", 192'(out_ctrl), (n > 0) ? 192'(q_ctrl[0]) : 192'(0));
    if (n > 0) check("out_data", 192'(out_data), 192'(q_data[0]));
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt", 192'(stall_cnt), 192'(m_stall));
    check("flush_cnt", 192'(flush_cnt), 192'(m_flush));
`endif
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_clear();
`ifdef PIPE_STAGE_PERF_EN
    m_stall = 0;
    m_flush = 0;
`endif
    check("rst_out_valid", 192'(out_valid), 192'(0));
    check("rst_out_ctrl", 192'(out_ctrl), 192'(0));
    check("rst_in_ready", 192'(in_ready), 192'(1));
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
    m_stall = 0;
    m_flush = 0;
`endif
    @(negedge clk);
    check("rst_out_data", 192'(out_data), 192'(0));
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    // Streaming 1..8 with downstream always ready
    for (int i = 1; i <= 8; i++)
      cycle(1'b1, DW'(i), CW'(i), 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Downstream stall with continuous input, then release
    for (int i = 0; i < 3; i++)
      cycle(1'b1, DW'(32'hA0 + i), CW'(32'h1A0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush while holding two entries, with a new entry offered
    cycle(1'b1, DW'(32'hB1), CW'(32'h1B1), 1'b0, 1'b0);
    cycle(1'b1, DW'(32'hB2), CW'(32'h1B2), 1'b0, 1'b0);
    cycle(1'b1, DW'(32'hB3), CW'(32'h1B3), 1'b1, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset with two entries held
    cycle(1'b1, DW'(32'hC1), CW'(32'h1C1), 1'b0, 1'b0);
    cycle(1'b1, DW'(32'hC2), CW'(32'h1C2), 1'b0, 1'b0);
    in_valid = 1'b0;
    do_reset();
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
    do_reset();
    cycle(1'b1, DW'(32'hD1), CW'(32'h1D1), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle(1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    check("perf_stall5", 192'(stall_cnt), 192'(5));
    check("perf_flush2", 192'(flush_cnt), 192'(2));
`endif

    // Random valid/ready/flush traffic
    for (int i = 0; i < 10000; i++)
      cycle(($urandom_range(0, 3) != 0), rand_data(), CW'($urandom()),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
